// File: rtl/proteus_ctrl_pkg.sv
// Shared definitions for the Proteus pipeline sequencer.
//   state_t : sequencer states
//   tag_t   : per-cycle tag carried alongside the data through NFU-1/2/3
//   ACC_LAT / NFU3_LAT : default pipeline latencies
package proteus_ctrl_pkg;

    // Cycles from tile issue to nfu2_out valid for that tile
    localparam int ACC_LAT  = 6;
    // Extra cycles from nfu2_nfu3 capture to nfu3_out valid
    localparam int NFU3_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COEF,
        ST_RUN,
        ST_GAP,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/proteus_tag_delay.sv
// Tag delay line: shift register of DEPTH tags, cleared by reset.
//   clk       : clock
//   rst_n     : synchronous active-low reset (clears every stage)
//   din       : tag entering this cycle (invalid tag on non-issue cycles)
//   taps      : taps[k] is the tag issued k+1 cycles ago
//   any_valid : at least one stage holds a valid tag
module proteus_tag_delay
    import proteus_ctrl_pkg::*;
#(
    parameter int DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t din,
    output tag_t taps [DEPTH],
    output logic any_valid
);

    tag_t             stage_reg [DEPTH];
    logic [DEPTH-1:0] valid_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
            assign taps[gi]      = stage_reg[gi];
            assign valid_vec[gi] = stage_reg[gi].valid;
        end
    endgenerate

    assign any_valid = |valid_vec;

endmodule

// File: rtl/proteus_pipe_ctrl.sv
// Proteus NFU-1/2/3 pipeline sequencer.
// Loads sigmoid coefficients, issues input tiles under valid/ready, and
// time-aligns the NBout load / write-select / write-enable strobes with the
// data moving through the pipeline via a tagged delay line.
// Ports:
//   clk, i_rst_n (sync active-low)       : clock / reset
//   i_start, i_num_in_tiles,
//   i_num_out_tiles, i_num_coef,
//   i_resume, i_final                    : layer configuration, latched on start
//   i_coef_valid, i_data_valid           : coefficient / tile present
//   o_data_ready                         : tile accepted when valid & ready
//   o_load_sigmoid_coef, o_load_nbout,
//   o_psum_zero, o_nbout_nfu2_nfu3,
//   o_nbout_wr_en                        : pipeline control strobes
//   o_busy, o_done                       : status
module proteus_pipe_ctrl #(
    parameter int CNT_W    = 10,
    parameter int COEF_W   = 5,
    parameter int ACC_LAT  = proteus_ctrl_pkg::ACC_LAT,
    parameter int NFU3_LAT = proteus_ctrl_pkg::NFU3_LAT,
    parameter int GAP      = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_in_tiles,
    input  logic [CNT_W-1:0]  i_num_out_tiles,
    input  logic [COEF_W-1:0] i_num_coef,
    input  logic              i_resume,
    input  logic              i_final,
    input  logic              i_coef_valid,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic              o_load_sigmoid_coef,
    output logic              o_load_nbout,
    output logic              o_psum_zero,
    output logic              o_nbout_nfu2_nfu3,
    output logic              o_nbout_wr_en,
    output logic              o_busy,
    output logic              o_done
);
    import proteus_ctrl_pkg::*;

    localparam int DEPTH = ACC_LAT + NFU3_LAT;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t            state_reg;
    logic [CNT_W-1:0]  n_in_reg, n_out_reg, in_cnt_reg, out_cnt_reg;
    logic [COEF_W-1:0] n_coef_reg, coef_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic              resume_reg, final_reg;

    logic handshake, in_last, out_last;
    tag_t push_tag;
    tag_t taps [DEPTH];
    logic any_valid;
    logic wr_nfu2, wr_nfu3;

    assign handshake = (state_reg == ST_RUN) && i_data_valid;
    assign in_last   = (in_cnt_reg == n_in_reg - CNT_W'(1));
    assign out_last  = (out_cnt_reg == n_out_reg - CNT_W'(1));

    // The pushed tag itself is tap 0; taps[k] of the delay line is tap k+1.
    always_comb begin
        push_tag = '0;
        if (handshake) begin
            push_tag.valid = 1'b1;
            push_tag.first = (in_cnt_reg == '0);
            push_tag.last  = in_last;
        end
    end

    proteus_tag_delay #(
        .DEPTH (DEPTH)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (i_rst_n),
        .din       (push_tag),
        .taps      (taps),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            n_in_reg     <= '0;
            n_out_reg    <= '0;
            n_coef_reg   <= '0;
            in_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            coef_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            resume_reg   <= 1'b0;
            final_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        n_in_reg     <= (i_num_in_tiles  == '0) ? CNT_W'(1) : i_num_in_tiles;
                        n_out_reg    <= (i_num_out_tiles == '0) ? CNT_W'(1) : i_num_out_tiles;
                        n_coef_reg   <= i_num_coef;
                        resume_reg   <= i_resume;
                        final_reg    <= i_final;
                        in_cnt_reg   <= '0;
                        out_cnt_reg  <= '0;
                        coef_cnt_reg <= '0;
                        gap_cnt_reg  <= '0;
                        state_reg    <= (i_num_coef != '0) ? ST_COEF : ST_RUN;
                    end
                end
                ST_COEF: begin
                    if (i_coef_valid) begin
                        if (coef_cnt_reg == n_coef_reg - COEF_W'(1)) begin
                            coef_cnt_reg <= '0;
                            state_reg    <= ST_RUN;
                        end else begin
                            coef_cnt_reg <= coef_cnt_reg + COEF_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_data_valid) begin
                        if (in_last) begin
                            in_cnt_reg <= '0;
                            if (out_last) begin
                                state_reg <= ST_DRAIN;
                            end else begin
                                out_cnt_reg <= out_cnt_reg + CNT_W'(1);
                                gap_cnt_reg <= '0;
                                state_reg   <= ST_GAP;
                            end
                        end else begin
                            in_cnt_reg <= in_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    // Bubble keeps the next tile's NBout load clear of the
                    // previous tile's last-product capture.
                    if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
                        gap_cnt_reg <= '0;
                        state_reg   <= ST_RUN;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!any_valid) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Tap ACC_LAT-1: seed the accumulator one cycle before the first product
    // leaves NFU-2. Tap ACC_LAT: NFU-2 partial ready. Tap ACC_LAT+NFU3_LAT:
    // NFU-3 result ready.
    assign wr_nfu2 = taps[ACC_LAT-1].valid && taps[ACC_LAT-1].last && !final_reg;
    assign wr_nfu3 = taps[DEPTH-1].valid && taps[DEPTH-1].last && final_reg;

    assign o_data_ready        = (state_reg == ST_RUN);
    assign o_load_sigmoid_coef = (state_reg == ST_COEF) && i_coef_valid;
    assign o_load_nbout        = taps[ACC_LAT-2].valid && taps[ACC_LAT-2].first;
    assign o_psum_zero         = o_load_nbout && !resume_reg;
    assign o_nbout_wr_en       = wr_nfu2 || wr_nfu3;
    assign o_busy              = (state_reg != ST_IDLE);
    assign o_done              = (state_reg == ST_DRAIN) && !any_valid;

    always_comb begin
        if (wr_nfu2) begin
            o_nbout_nfu2_nfu3 = 1'b1;
        end else if (wr_nfu3) begin
            o_nbout_nfu2_nfu3 = 1'b0;
        end else begin
            o_nbout_nfu2_nfu3 = o_busy && !final_reg;
        end
    end

endmodule
